fir_uart_controller: RTL and testbench
======================================

Name: fir_uart_controller

Overview:
- Control FSM that sequences the UART-fed 16-bit FIR datapath: receive LSB then MSB byte, fire one FIR sample, capture the result, then transmit result LSB then MSB over UART.
- Drives every datapath load/select/start strobe; consumes RxD_data_ready, output_valid and TxD_busy.
- Processes one sample at a time; also reports a processed-sample count and a sticky overrun flag.

Parameters:
- FIR_TIMEOUT, 255: max cycles spent in S_FIR_WAIT before abort (used only with the optional feature).
- CNT_WIDTH, 16: width of sample_count.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- RxD_data_ready  in  1  one-cycle pulse, byte valid on UART RxD_data
- output_valid  in  1  FIR result valid (pulse or level)
- TxD_busy  in  1  UART transmitter busy
- Load_FIR_In_LSB  out  1  load received byte into FIR input[7:0]
- Load_FIR_In_MSB  out  1  load received byte into FIR input[15:8]
- input_valid  out  1  one-cycle FIR sample strobe
- Load_FIR_OUT  out  1  capture FIR_output[15:0] into output registers
- TxD_data_select  out  1  0 = transmit LSB register, 1 = MSB register
- TxD_start  out  1  one-cycle UART transmit request
- busy  out  1  high in every state except S_RX_LSB
- sample_count  out  CNT_WIDTH  samples fully transmitted, wraps modulo 2^CNT_WIDTH
- overrun  out  1  sticky: a byte arrived while not in a receive state
- timeout_err  out  1  sticky FIR timeout flag (tied 0 when feature disabled)

Behaviour:
- Reset (sync, high): state = S_RX_LSB, all strobes 0, TxD_data_select 0, sample_count 0, overrun 0, timeout_err 0. Reset in any state aborts mid-operation; a partial sample is discarded and a TxD_start already issued is not retracted.
- S_RX_LSB: Load_FIR_In_LSB = RxD_data_ready (Mealy, same cycle as the pulse); on the pulse go to S_RX_MSB.
- S_RX_MSB: Load_FIR_In_MSB = RxD_data_ready; on the pulse go to S_FIR_START.
- S_FIR_START: input_valid = 1 for exactly one cycle; go to S_FIR_WAIT. This is the cycle after the MSB load, so FIR_input is already stable.
- S_FIR_WAIT: stay until output_valid = 1, then go to S_LATCH. If output_valid is already high on entry, exit after 1 cycle.
- S_LATCH: Load_FIR_OUT = 1 for one cycle; go to S_TX_LSB.
- S_TX_LSB: TxD_data_select = 0. When TxD_busy = 0, assert TxD_start for one cycle and go to S_TXW_LSB; otherwise hold.
- S_TXW_LSB: TxD_data_select = 0. Set seen_busy when TxD_busy = 1. Go to S_TX_MSB once seen_busy is set and TxD_busy = 0. If busy never rises within 2 cycles of the start, treat the byte as sent.
- S_TX_MSB / S_TXW_MSB: identical to the LSB pair with TxD_data_select = 1. On completion: sample_count += 1 and return to S_RX_LSB.
- Overrun: an RxD_data_ready pulse in any state other than S_RX_LSB/S_RX_MSB sets overrun (sticky until reset). The byte is dropped and no load is issued.
- Simultaneous events: RxD_data_ready on the same cycle the FSM returns to S_RX_LSB counts as overrun (the state is not yet S_RX_LSB).
- All outputs except the two Mealy load strobes are decoded from registered state. Strobes are never high for more than 1 cycle per transition.
- Latency: MSB byte pulse to input_valid = 1 cycle; output_valid to Load_FIR_OUT = 1 cycle; Load_FIR_OUT to first TxD_start = 1 cycle if TxD_busy = 0.

Optional Feature:
- Macro FIR_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on entry to S_FIR_WAIT and increments each cycle there. When it reaches FIR_TIMEOUT without output_valid, set timeout_err (sticky), skip transmit, return to S_RX_LSB, and leave sample_count unchanged.
- Undefined: no counter; S_FIR_WAIT waits indefinitely; timeout_err constant 0.

Test Plan:
- Reset then bytes 0x34, 0x12 -> Load_FIR_In_LSB on the 1st pulse cycle, Load_FIR_In_MSB on the 2nd, input_valid exactly 1 cycle later; overrun = 0.
- output_valid raised 10 cycles after input_valid, UART model busy for 20 cycles per byte -> Load_FIR_OUT 1 cycle after output_valid, TxD_start with select = 0, then TxD_start with select = 1 only after busy falls; sample_count = 1.
- TxD_busy held high 50 cycles when entering S_TX_LSB -> no TxD_start until busy drops, then exactly one pulse.
- Extra RxD_data_ready during S_FIR_WAIT -> overrun = 1, no load strobe; the next sample processes normally and overrun stays 1.
- Reset asserted in S_TXW_LSB -> next cycle busy = 0, all strobes 0, sample_count = 0, state S_RX_LSB.
- FIR_TIMEOUT_EN with FIR_TIMEOUT = 16 and output_valid never asserted -> timeout_err = 1 after 16 cycles in wait, no TxD_start, back in S_RX_LSB (busy = 0), sample_count unchanged.

Source files
------------

// File: rtl/fir_uart_controller.sv
// Control FSM for the UART-fed 16-bit FIR datapath: two bytes in, one FIR sample, two bytes out.
// Define FIR_TIMEOUT_EN to bound the wait for the FIR result and report timeouts on timeout_err.
module fir_uart_controller #(
  parameter int FIR_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD_data_ready,
  input  logic                 output_valid,
  input  logic                 TxD_busy,
  output logic                 Load_FIR_In_LSB,
  output logic                 Load_FIR_In_MSB,
  output logic                 input_valid,
  output logic                 Load_FIR_OUT,
  output logic                 TxD_data_select,
  output logic                 TxD_start,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic                 overrun,
  output logic                 timeout_err
);

  typedef enum logic [3:0] {
    S_RX_LSB,
    S_RX_MSB,
    S_FIR_START,
    S_FIR_WAIT,
    S_LATCH,
    S_TX_LSB,
    S_TXW_LSB,
    S_TX_MSB,
    S_TXW_MSB
  } state_t;

  state_t               state_q, state_d;
  logic                 seenBusy_q, seenBusy_d;
  logic                 txwCnt_q, txwCnt_d;
  logic [CNT_WIDTH-1:0] sampleCount_q, sampleCount_d;
  logic                 overrun_q, overrun_d;

`ifdef FIR_TIMEOUT_EN
  localparam int TW = ($clog2(FIR_TIMEOUT + 1) < 8) ? 8 : $clog2(FIR_TIMEOUT + 1);
  logic [TW-1:0] firCnt_q, firCnt_d;
  logic          timeout_q, timeout_d;
`else
  logic [31:0] unusedTimeout;
  assign unusedTimeout = 32'(FIR_TIMEOUT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RX_LSB;
      seenBusy_q    <= 1'b0;
      txwCnt_q      <= 1'b0;
      sampleCount_q <= '0;
      overrun_q     <= 1'b0;
`ifdef FIR_TIMEOUT_EN
      firCnt_q      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      seenBusy_q    <= seenBusy_d;
      txwCnt_q      <= txwCnt_d;
      sampleCount_q <= sampleCount_d;
      overrun_q     <= overrun_d;
`ifdef FIR_TIMEOUT_EN
      firCnt_q      <= firCnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  // A byte arriving outside the two receive states is dropped and flagged.
  always_comb begin
    state_d         = state_q;
    seenBusy_d      = seenBusy_q;
    txwCnt_d        = txwCnt_q;
    sampleCount_d   = sampleCount_q;
    overrun_d       = overrun_q |
                      (RxD_data_ready && (state_q != S_RX_LSB) && (state_q != S_RX_MSB));
    Load_FIR_In_LSB = 1'b0;
    Load_FIR_In_MSB = 1'b0;
    input_valid     = 1'b0;
    Load_FIR_OUT    = 1'b0;
    TxD_data_select = 1'b0;
    TxD_start       = 1'b0;
`ifdef FIR_TIMEOUT_EN
    firCnt_d        = firCnt_q;
    timeout_d       = timeout_q;
`endif

    case (state_q)
      S_RX_LSB: begin
        Load_FIR_In_LSB = RxD_data_ready;
        if (RxD_data_ready) state_d = S_RX_MSB;
      end
      S_RX_MSB: begin
        Load_FIR_In_MSB = RxD_data_ready;
        if (RxD_data_ready) state_d = S_FIR_START;
      end
      S_FIR_START: begin
        input_valid = 1'b1;
        state_d     = S_FIR_WAIT;
`ifdef FIR_TIMEOUT_EN
        firCnt_d    = '0;
`endif
      end
      S_FIR_WAIT: begin
        if (output_valid) begin
          state_d = S_LATCH;
        end else begin
`ifdef FIR_TIMEOUT_EN
          firCnt_d = firCnt_q + TW'(1);
          if (firCnt_q + TW'(1) == TW'(FIR_TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = S_RX_LSB;
          end
`endif
        end
      end
      S_LATCH: begin
        Load_FIR_OUT = 1'b1;
        state_d      = S_TX_LSB;
      end
      S_TX_LSB: begin
        seenBusy_d = 1'b0;
        txwCnt_d   = 1'b0;
        if (!TxD_busy) begin
          TxD_start = 1'b1;
          state_d   = S_TXW_LSB;
        end
      end
      // A transmitter that never raises busy within two cycles is taken as done.
      S_TXW_LSB: begin
        txwCnt_d = 1'b1;
        if (TxD_busy) seenBusy_d = 1'b1;
        if (!TxD_busy && (seenBusy_q || txwCnt_q)) state_d = S_TX_MSB;
      end
      S_TX_MSB: begin
        TxD_data_select = 1'b1;
        seenBusy_d      = 1'b0;
        txwCnt_d        = 1'b0;
        if (!TxD_busy) begin
          TxD_start = 1'b1;
          state_d   = S_TXW_MSB;
        end
      end
      S_TXW_MSB: begin
        TxD_data_select = 1'b1;
        txwCnt_d        = 1'b1;
        if (TxD_busy) seenBusy_d = 1'b1;
        if (!TxD_busy && (seenBusy_q || txwCnt_q)) begin
          sampleCount_d = sampleCount_q + CNT_WIDTH'(1);
          state_d       = S_RX_LSB;
        end
      end
      default: state_d = S_RX_LSB;
    endcase
  end

  assign busy         = (state_q != S_RX_LSB);
  assign sample_count = sampleCount_q;
  assign overrun      = overrun_q;
`ifdef FIR_TIMEOUT_EN
  assign timeout_err  = timeout_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fir_uart_controller.sv
// Directed bench for fir_uart_controller with a small UART transmitter model.
// Build with FIR_TIMEOUT_EN defined to exercise the FIR wait timeout.
module tb_fir_uart_controller;

  logic        clk;
  logic        reset;
  logic        RxD_data_ready;
  logic        output_valid;
  logic        TxD_busy;
  logic        Load_FIR_In_LSB;
  logic        Load_FIR_In_MSB;
  logic        input_valid;
  logic        Load_FIR_OUT;
  logic        TxD_data_select;
  logic        TxD_start;
  logic        busy;
  logic [15:0] sample_count;
  logic        overrun;
  logic        timeout_err;

  int checks    = 0;
  int passes    = 0;
  int startCount = 0;
  int busyCnt   = 0;
  logic forceBusy = 1'b0;
  logic muteModel = 1'b0;

  fir_uart_controller #(.FIR_TIMEOUT(16), .CNT_WIDTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .RxD_data_ready  (RxD_data_ready),
    .output_valid    (output_valid),
    .TxD_busy        (TxD_busy),
    .Load_FIR_In_LSB (Load_FIR_In_LSB),
    .Load_FIR_In_MSB (Load_FIR_In_MSB),
    .input_valid     (input_valid),
    .Load_FIR_OUT    (Load_FIR_OUT),
    .TxD_data_select (TxD_data_select),
    .TxD_start       (TxD_start),
    .busy            (busy),
    .sample_count    (sample_count),
    .overrun         (overrun),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART transmitter: busy for 20 cycles after each start unless muted.
  always @(posedge clk) begin
    if (reset) busyCnt <= 0;
    else if (TxD_start && !muteModel) busyCnt <= 20;
    else if (busyCnt != 0) busyCnt <= busyCnt - 1;
  end
  assign TxD_busy = (busyCnt != 0) || forceBusy;

  always @(negedge clk) if (TxD_start) startCount <= startCount + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rx, input logic ov);
    RxD_data_ready = rx;
    output_valid   = ov;
    #1;
  endtask

  // Receives 0x34 then 0x12; leaves the DUT in its first FIR-wait cycle.
  task automatic sendSample(input logic expOverrun);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ld_lsb", Load_FIR_In_LSB, 1);
    checkOutput("ld_msb_quiet", Load_FIR_In_MSB, 0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("busy_rx_msb", busy, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ld_msb", Load_FIR_In_MSB, 1);
    checkOutput("ld_lsb_quiet", Load_FIR_In_LSB, 0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("input_valid", input_valid, 1);
    checkOutput("overrun_rx", overrun, expOverrun);
    tick();
    checkOutput("input_valid_1cyc", input_valid, 0);
  endtask

  task automatic waitStart(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cycles++;
      if (TxD_start) break;
    end
    if (!TxD_start) checkOutput("start_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick();
    end
    checkOutput("idle", busy, 0);
  endtask

  // From FIR wait: result valid, latch, both bytes out, back to idle.
  task automatic finishSample(input int expGap);
    int gap;
    int base;
    base = startCount;
    applyStimulus(1'b0, 1'b1);
    checkOutput("latch_early", Load_FIR_OUT, 0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("latch", Load_FIR_OUT, 1);
    tick();
    checkOutput("latch_1cyc", Load_FIR_OUT, 0);
    checkOutput("start_lsb", TxD_start, 1);
    checkOutput("sel_lsb", TxD_data_select, 0);
    waitStart(gap);
    checkOutput("start_gap", gap, expGap);
    checkOutput("sel_msb", TxD_data_select, 1);
    waitIdle();
    checkOutput("start_total", startCount - base, 2);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    RxD_data_ready = 1'b0;
    output_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", sample_count, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_sel", TxD_data_select, 0);
    checkOutput("rst_strobes", {input_valid, Load_FIR_OUT, TxD_start}, 0);

    $display("[TB] normal sample, result 10 cycles after input_valid");
    sendSample(1'b0);
    repeat (8) tick();
    finishSample(22);
    checkOutput("count_1", sample_count, 1);

    $display("[TB] transmitter held busy on entry");
    base = startCount;
    forceBusy = 1'b1;
    sendSample(1'b0);
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("latch_level", Load_FIR_OUT, 1);
    tick();
    checkOutput("start_held", TxD_start, 0);
    repeat (49) tick();
    checkOutput("no_start_busy", startCount - base, 0);
    forceBusy = 1'b0;
    #1;
    checkOutput("start_release", TxD_start, 1);
    tick();
    checkOutput("start_1cyc", TxD_start, 0);
    waitIdle();
    checkOutput("start_total_held", startCount - base, 2);
    checkOutput("count_2", sample_count, 2);

    $display("[TB] overrun in FIR wait, silent transmitter");
    muteModel = 1'b1;
    sendSample(1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ovr_no_lsb", Load_FIR_In_LSB, 0);
    checkOutput("ovr_no_msb", Load_FIR_In_MSB, 0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("overrun_set", overrun, 1);
    finishSample(3);
    checkOutput("count_3", sample_count, 3);
    sendSample(1'b1);
    finishSample(3);
    checkOutput("count_4", sample_count, 4);
    checkOutput("overrun_sticky", overrun, 1);
    muteModel = 1'b0;

    $display("[TB] reset while waiting on LSB transmit");
    sendSample(1'b1);
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("start_pre_rst", TxD_start, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_count", sample_count, 0);
    checkOutput("mid_rst_overrun", overrun, 0);
    checkOutput("mid_rst_strobes", {input_valid, Load_FIR_OUT, TxD_start, TxD_data_select}, 0);

    $display("[TB] FIR result never arrives");
    base = startCount;
    sendSample(1'b0);
`ifdef FIR_TIMEOUT_EN
    repeat (15) tick();
    checkOutput("to_wait16_busy", busy, 1);
    checkOutput("to_wait16_err", timeout_err, 0);
    tick();
    checkOutput("to_idle", busy, 0);
    checkOutput("to_err", timeout_err, 1);
    checkOutput("to_no_start", startCount - base, 0);
    checkOutput("to_count", sample_count, 0);
`else
    repeat (40) tick();
    checkOutput("wait_forever", busy, 1);
    checkOutput("no_timeout", timeout_err, 0);
    finishSample(22);
    checkOutput("count_after_wait", sample_count, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
